// File: rtl/edib_m57_tx_if.sv
// Signal bundle for the EDIB M57 frame transmitter.
// Carries the source inputs, the differential line outputs and the debug taps.
interface edib_m57_tx_if;
  logic [15:0] M57In;
  logic [15:0] DataLength;
  logic        Speed;
  logic        OutP;
  logic        OutN;
  logic        TxDone;
  logic        Finished;
  logic        Busy;
  logic [4:0]  State;
  logic [4:0]  NextState;
  logic [15:0] RegM57In;
  logic [15:0] RegDataTimes;
  logic [13:0] SynReg;
  logic        Sclk;
  logic [11:0] SclkCounts;
  logic [7:0]  SynReg22bitsCounts;
  logic [31:0] Data32bits;
  logic [7:0]  Data32bitsCounts;

  modport master (
    input  M57In, DataLength, Speed,
    output OutP, OutN, TxDone, Finished, Busy, State, NextState,
           RegM57In, RegDataTimes, SynReg, Sclk, SclkCounts,
           SynReg22bitsCounts, Data32bits, Data32bitsCounts
  );

  modport slave (
    output M57In, DataLength, Speed,
    input  OutP, OutN, TxDone, Finished, Busy, State, NextState,
           RegM57In, RegDataTimes, SynReg, Sclk, SclkCounts,
           SynReg22bitsCounts, Data32bits, Data32bitsCounts
  );
endinterface

// File: rtl/edib_m57_tx.sv
// EDIB M57 serial frame transmitter: 22-bit header (sync + length byte), then
// DataLength words of {index, M57In}, NRZ MSB first on a differential pair.
module edib_m57_tx #(
  parameter logic [13:0] SYNC_PATTERN = 14'h3F80,
  parameter int          FAST_PERIOD  = 48,
  parameter int          SLOW_PERIOD  = 2400
) (
  input logic           Clk,
  input logic           Rstn,
  edib_m57_tx_if.master bus
);

  typedef enum logic [4:0] {
    IDLE     = 5'd0,
    LOAD     = 5'd1,
    SYNC     = 5'd2,
    LATCH    = 5'd3,
    DATA     = 5'd4,
    WORDDONE = 5'd5,
    DONE     = 5'd6
  } state_t;

  state_t      state, nextState;
  logic        speedReg, busy, finished, txDone, outP, sclk;
  logic        busyNext, bitTick;
  logic [11:0] sclkCounts, cntNext, period;
  logic [7:0]  synCnt, dataCnt;
  logic [13:0] synReg;
  logic [31:0] data32;
  logic [15:0] regM57In, regDataTimes;

  assign period  = speedReg ? 12'(FAST_PERIOD) : 12'(SLOW_PERIOD);
  assign bitTick = busy && (sclkCounts == period - 12'd1);

  always_comb begin
    nextState = state;
    case (state)
      IDLE:     if (bus.DataLength != 16'd0 && !finished) nextState = LOAD;
      LOAD:     nextState = SYNC;
      SYNC:     if (bitTick && synCnt == 8'd21) nextState = LATCH;
      LATCH:    nextState = DATA;
      DATA:     if (bitTick && dataCnt == 8'd31) nextState = WORDDONE;
      // Live compare: a shrinking DataLength ends the frame at this word.
      WORDDONE: nextState = (regDataTimes >= bus.DataLength) ? DONE : LATCH;
      DONE:     if (bus.DataLength == 16'd0) nextState = IDLE;
      default:  nextState = IDLE;
    endcase
  end

  // Bit counter runs straight through LATCH/WORDDONE so every line bit is P clocks.
  always_comb begin
    busyNext = (nextState == SYNC) || (nextState == LATCH) ||
               (nextState == DATA) || (nextState == WORDDONE);
    cntNext  = (!busy || !busyNext || bitTick) ? 12'd0 : sclkCounts + 12'd1;
  end

  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      state        <= IDLE;
      speedReg     <= 1'b0;
      busy         <= 1'b0;
      finished     <= 1'b0;
      txDone       <= 1'b0;
      outP         <= 1'b0;
      sclk         <= 1'b0;
      sclkCounts   <= 12'd0;
      synCnt       <= 8'd0;
      dataCnt      <= 8'd0;
      synReg       <= 14'd0;
      data32       <= 32'd0;
      regM57In     <= 16'd0;
      regDataTimes <= 16'd0;
    end else begin
      state      <= nextState;
      txDone     <= (nextState == WORDDONE);
      sclkCounts <= cntNext;
      sclk       <= busyNext && (cntNext >= (period >> 1));
      case (state)
        IDLE: outP <= 1'b0;
        LOAD: begin
          busy         <= 1'b1;
          speedReg     <= bus.Speed;
          synReg       <= SYNC_PATTERN;
          regDataTimes <= 16'd0;
          synCnt       <= 8'd0;
          outP         <= SYNC_PATTERN[13];
        end
        // The line register always loads the bit that starts after this tick.
        SYNC: if (bitTick) begin
          synReg <= {synReg[12:0], 1'b0};
          if (synCnt == 8'd21) begin
            outP <= regDataTimes[15];
          end else begin
            synCnt <= synCnt + 8'd1;
            if (synCnt < 8'd13) outP <= synReg[12];
            else                outP <= bus.DataLength[3'(8'd20 - synCnt)];
          end
        end
        LATCH: begin
          regM57In     <= bus.M57In;
          data32       <= {regDataTimes, bus.M57In};
          dataCnt      <= 8'd0;
          regDataTimes <= regDataTimes + 16'd1;
        end
        DATA: if (bitTick) begin
          data32 <= {data32[30:0], 1'b0};
          if (dataCnt == 8'd31) begin
            outP <= (regDataTimes >= bus.DataLength) ? 1'b0 : regDataTimes[15];
          end else begin
            outP    <= data32[30];
            dataCnt <= dataCnt + 8'd1;
          end
        end
        WORDDONE: if (nextState == DONE) begin
          busy     <= 1'b0;
          finished <= 1'b1;
          outP     <= 1'b0;
        end
        DONE: begin
          outP <= 1'b0;
          if (nextState == IDLE) finished <= 1'b0;
        end
        default: outP <= 1'b0;
      endcase
    end
  end

  assign bus.OutP               = outP;
  assign bus.OutN               = ~outP;
  assign bus.TxDone             = txDone;
  assign bus.Finished           = finished;
  assign bus.Busy               = busy;
  assign bus.State              = state;
  assign bus.NextState          = nextState;
  assign bus.RegM57In           = regM57In;
  assign bus.RegDataTimes       = regDataTimes;
  assign bus.SynReg             = synReg;
  assign bus.Sclk               = sclk;
  assign bus.SclkCounts         = sclkCounts;
  assign bus.SynReg22bitsCounts = synCnt;
  assign bus.Data32bits         = data32;
  assign bus.Data32bitsCounts   = dataCnt;

endmodule

// File: tb/tb_edib_m57_tx.sv
// Scoreboard bench for edib_m57_tx: the line is decoded at each Sclk rise and
// compared against header/word/frame-end expectations queued by the stimulus.
module tb_edib_m57_tx;
  localparam int FAST_P = 48;
  localparam int SLOW_P = 300;
  localparam int KHDR = 0, KWORD = 1, KEND = 2;

  typedef struct {
    int          kind;
    logic [31:0] value;
    int          aux;
  } exp_t;

  logic Clk = 1'b0;
  logic Rstn = 1'b0;
  always #5 Clk = ~Clk;

  edib_m57_tx_if bus();

  edib_m57_tx #(
    .SYNC_PATTERN(14'h3F80),
    .FAST_PERIOD (FAST_P),
    .SLOW_PERIOD (SLOW_P)
  ) dut (
    .Clk (Clk),
    .Rstn(Rstn),
    .bus (bus)
  );

  int   checks = 0;
  int   failures = 0;
  exp_t sbq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic popExp(input int kind, output exp_t e, output bit ok);
    ok = 1'b0;
    e  = '{-1, 32'd0, 0};
    if (sbq.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_underflow kind=%0d actual=empty required=entry", kind);
      return;
    end
    e = sbq.pop_front();
    check("sb_kind", 32'(e.kind), 32'(kind));
    ok = (e.kind == kind);
  endtask

  // Monitor: line decoder and scoreboard consumer
  int          cyc = 0, polErr = 0, bitCnt = 0, lastRise = -1;
  int          minIv = 1 << 30, maxIv = 0, txSeen = 0, curP = 0;
  logic [31:0] shreg = 32'd0;
  logic        prevSclk = 1'b0, prevFin = 1'b0;

  always @(negedge Clk) begin : mon
    exp_t e;
    bit   ok;
    int   iv;
    cyc++;
    if (bus.OutN !== ~bus.OutP) polErr++;
    if (!Rstn) begin
      bitCnt = 0; lastRise = -1; minIv = 1 << 30; maxIv = 0; txSeen = 0;
      shreg = 32'd0; prevSclk = 1'b0; prevFin = 1'b0;
    end else begin
      if (bus.Sclk && !prevSclk) begin
        shreg = {shreg[30:0], bus.OutP};
        bitCnt++;
        if (lastRise >= 0) begin
          iv = cyc - lastRise;
          if (iv < minIv) minIv = iv;
          if (iv > maxIv) maxIv = iv;
        end
        lastRise = cyc;
        if (bitCnt == 22) begin
          popExp(KHDR, e, ok);
          if (ok) begin
            check("header", {10'd0, shreg[21:0]}, e.value);
            curP = e.aux;
          end
        end
      end
      prevSclk = bus.Sclk;
      if (bus.TxDone) begin
        popExp(KWORD, e, ok);
        if (ok) begin
          check("word_line", shreg, e.value);
          check("reg_m57in", {16'd0, bus.RegM57In}, {16'd0, e.value[15:0]});
          check("reg_datatimes", {16'd0, bus.RegDataTimes}, {16'd0, e.value[31:16] + 16'd1});
        end
        check("bits_before_txdone", 32'(bitCnt), 32'(22 + 32 * (txSeen + 1)));
        txSeen++;
      end
      if (bus.Finished && !prevFin) begin
        popExp(KEND, e, ok);
        if (ok) check("txdone_count", 32'(txSeen), e.value);
        check("sclk_period_min", 32'(minIv), 32'(curP));
        check("sclk_period_max", 32'(maxIv), 32'(curP));
        check("busy_after_done", {31'd0, bus.Busy}, 32'd0);
        check("line_idle_done", {31'd0, bus.OutP}, 32'd0);
        bitCnt = 0; lastRise = -1; minIv = 1 << 30; maxIv = 0; txSeen = 0;
      end
      prevFin = bus.Finished;
    end
  end

  task automatic runFrame(input logic spd, input int len, input bit fixedData);
    int          p, n, budget, elapsed, frame;
    logic [15:0] m, L;
    p       = spd ? FAST_P : SLOW_P;
    L       = 16'(len);
    budget  = 60 * p;
    elapsed = 0;
    m       = fixedData ? 16'hFFFF : 16'($urandom);
    bus.Speed = spd;
    bus.M57In = m;
    sbq.push_back('{KHDR, {10'd0, 14'h3F80, L[7:0]}, p});
    sbq.push_back('{KWORD, {16'd0, m}, 0});
    bus.DataLength = L;
    for (int w = 0; w < len; w++) begin
      n = 0;
      do begin @(negedge Clk); n++; elapsed++; end while (!bus.TxDone && n < budget);
      if (!bus.TxDone) begin
        checks++; failures++;
        $display("FAIL txdone_timeout word=%0d actual=none required=pulse", w);
        return;
      end
      if (w == 0) check("busy_in_frame", {31'd0, bus.Busy}, 32'd1);
      if (w + 1 < len) begin
        m = fixedData ? 16'hFFFF : 16'($urandom);
        bus.M57In = m;
        sbq.push_back('{KWORD, {16'(w + 1), m}, 0});
      end else begin
        sbq.push_back('{KEND, 32'(len), 0});
      end
    end
    n = 0;
    while (!bus.Finished && n < budget) begin @(negedge Clk); n++; elapsed++; end
    if (!bus.Finished) begin
      checks++; failures++;
      $display("FAIL finished_timeout actual=0 required=1");
      return;
    end
    frame = (22 + 32 * len) * p;
    check("frame_len_min", {31'd0, elapsed >= frame}, 32'd1);
    check("frame_len_max", {31'd0, elapsed <= frame + 2 * len + 4}, 32'd1);
    check("done_datatimes", {16'd0, bus.RegDataTimes}, {16'd0, L});
    bus.DataLength = 16'd0;
    repeat (2) @(negedge Clk);
    check("rearm_state", {27'd0, bus.State}, 32'd0);
    check("rearm_finished", {31'd0, bus.Finished}, 32'd0);
  endtask

  task automatic checkResetValues(input string tag);
    check({tag, "_state"}, {27'd0, bus.State}, 32'd0);
    check({tag, "_outp"}, {31'd0, bus.OutP}, 32'd0);
    check({tag, "_outn"}, {31'd0, bus.OutN}, 32'd1);
    check({tag, "_busy"}, {31'd0, bus.Busy}, 32'd0);
    check({tag, "_finished"}, {31'd0, bus.Finished}, 32'd0);
    check({tag, "_txdone"}, {31'd0, bus.TxDone}, 32'd0);
    check({tag, "_sclkcounts"}, {20'd0, bus.SclkCounts}, 32'd0);
  endtask

  initial begin
    int          n, txAfter;
    logic [15:0] m;
    bus.DataLength = 16'd0;
    bus.Speed      = 1'b1;
    bus.M57In      = 16'd0;
    repeat (3) @(negedge Clk);
    checkResetValues("reset");
    Rstn = 1'b1;
    repeat (5) @(negedge Clk);
    check("idle_zero_len", {27'd0, bus.State}, 32'd0);

    runFrame(1'b1, 10, 1'b1);
    runFrame(1'b0, 1, 1'b0);
    runFrame(1'b1, 4, 1'b0);
    runFrame(1'b1, 2, 1'b0);
    for (int k = 0; k < 2; k++) runFrame(1'b1, int'($urandom_range(1, 3)), 1'b0);
    check("queue_drained", 32'(sbq.size()), 32'd0);

    // Abort in the middle of the second data word
    m = 16'($urandom);
    bus.Speed = 1'b1;
    bus.M57In = m;
    sbq.push_back('{KHDR, {10'd0, 14'h3F80, 8'd3}, FAST_P});
    sbq.push_back('{KWORD, {16'd0, m}, 0});
    bus.DataLength = 16'd3;
    n = 0;
    do begin @(negedge Clk); n++; end while (!bus.TxDone && n < 60 * FAST_P);
    check("abort_first_txdone", {31'd0, bus.TxDone}, 32'd1);
    repeat (100) @(negedge Clk);
    check("abort_in_data", {27'd0, bus.State}, 32'd4);
    #2 Rstn = 1'b0;
    #1 checkResetValues("abort");
    sbq.delete();
    bus.DataLength = 16'd0;
    repeat (3) @(negedge Clk);
    Rstn = 1'b1;
    txAfter = 0;
    repeat (600) begin
      @(negedge Clk);
      if (bus.TxDone) txAfter++;
    end
    check("abort_no_txdone", 32'(txAfter), 32'd0);
    check("abort_idle", {27'd0, bus.State}, 32'd0);
    check("outn_complement", 32'(polErr), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
